// File: rtl/rgb_to_yuv444.sv
// Two-pixel-per-word RGB to YUV444 (BT.601 studio range) converter, 3-stage elastic pipeline.
// Optional frame statistics outputs are enabled by defining RGB_TO_YUV444_STATS_EN.
module rgb_to_yuv444 #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  src_valid,
  output logic                  src_ready,
  input  logic [DATA_WIDTH-1:0] src_data,
  input  logic                  src_last,
  output logic                  dst_valid,
  input  logic                  dst_ready,
  output logic [DATA_WIDTH-1:0] dst_data,
  output logic                  dst_last
`ifdef RGB_TO_YUV444_STATS_EN
  ,
  output logic [31:0]           frame_words,
  output logic                  frame_done
`endif
);

  localparam int PIX    = 2;
  localparam int COEF_W = 10;
  localparam int PROD_W = 18;

  // Row-major: Y, U, V rows; columns R, G, B.
  localparam logic signed [COEF_W-1:0] COEF [9] = '{
    10'sd66,  10'sd129, 10'sd25,
    -10'sd38, -10'sd74, 10'sd112,
    10'sd112, -10'sd94, -10'sd18
  };
  localparam logic [8:0] OFFS [3] = '{9'd16, 9'd128, 9'd128};

  function automatic logic signed [PROD_W-1:0] mul_coef(input logic [7:0] x,
                                                        input logic signed [COEF_W-1:0] c);
    logic signed [PROD_W-1:0] xs;
    logic signed [PROD_W-1:0] cs;
    xs = {{(PROD_W-8){1'b0}}, x};
    cs = {{(PROD_W-COEF_W){c[COEF_W-1]}}, c};
    return xs * cs;
  endfunction

  function automatic logic [7:0] sat_pix(input logic signed [PROD_W-1:0] s,
                                         input logic [8:0] off);
    logic signed [PROD_W-1:0] t;
    t = (s >>> 8) + $signed({{(PROD_W-9){1'b0}}, off});
    if (t < 0)
      return 8'd0;
    else if (t > 255)
      return 8'd255;
    else
      return t[7:0];
  endfunction

  logic                     vld_p0_q, vld_p0_d;
  logic                     vld_p1_q, vld_p1_d;
  logic                     vld_p2_q, vld_p2_d;
  logic                     last_p0_q, last_p0_d;
  logic                     last_p1_q, last_p1_d;
  logic                     last_p2_q, last_p2_d;
  logic signed [PROD_W-1:0] prod_p0_q [PIX][9];
  logic signed [PROD_W-1:0] prod_p0_d [PIX][9];
  logic signed [PROD_W-1:0] sum_p1_q  [PIX][3];
  logic signed [PROD_W-1:0] sum_p1_d  [PIX][3];
  logic [23:0]              pix_p2_q  [PIX];
  logic [23:0]              pix_p2_d  [PIX];

  logic rdy_p0, rdy_p1, rdy_p2;
  logic unused_pad;

  // A stage can take new contents when empty or when its word leaves this cycle.
  assign rdy_p2    = ~vld_p2_q | dst_ready;
  assign rdy_p1    = ~vld_p1_q | rdy_p2;
  assign rdy_p0    = ~vld_p0_q | rdy_p1;
  assign src_ready = rdy_p0 & ~rst;
  assign unused_pad = ^{src_data[63:56], src_data[31:24]};

  always_comb begin
    vld_p0_d  = rdy_p0 ? src_valid : vld_p0_q;
    vld_p1_d  = rdy_p1 ? vld_p0_q  : vld_p1_q;
    vld_p2_d  = rdy_p2 ? vld_p1_q  : vld_p2_q;
    last_p0_d = last_p0_q;
    last_p1_d = last_p1_q;
    last_p2_d = last_p2_q;
    if (rdy_p0 && src_valid) last_p0_d = src_last;
    if (rdy_p1 && vld_p0_q)  last_p1_d = last_p0_q;
    if (rdy_p2 && vld_p1_q)  last_p2_d = last_p1_q;
  end

  // S1: per-channel coefficient products
  always_comb begin
    prod_p0_d = prod_p0_q;
    if (rdy_p0 && src_valid) begin
      for (int p = 0; p < PIX; p++) begin
        for (int k = 0; k < 3; k++) begin
          prod_p0_d[p][3*k]   = mul_coef(src_data[32*p+16 +: 8], COEF[3*k]);
          prod_p0_d[p][3*k+1] = mul_coef(src_data[32*p+8  +: 8], COEF[3*k+1]);
          prod_p0_d[p][3*k+2] = mul_coef(src_data[32*p    +: 8], COEF[3*k+2]);
        end
      end
    end
  end

  // S2: row sums including the rounding constant
  always_comb begin
    sum_p1_d = sum_p1_q;
    if (rdy_p1 && vld_p0_q) begin
      for (int p = 0; p < PIX; p++) begin
        for (int k = 0; k < 3; k++) begin
          sum_p1_d[p][k] = prod_p0_q[p][3*k] + prod_p0_q[p][3*k+1] +
                           prod_p0_q[p][3*k+2] + 18'sd128;
        end
      end
    end
  end

  // S3: scale, offset and clamp into {V, U, Y}
  always_comb begin
    pix_p2_d = pix_p2_q;
    if (rdy_p2 && vld_p1_q) begin
      for (int p = 0; p < PIX; p++) begin
        pix_p2_d[p] = {sat_pix(sum_p1_q[p][2], OFFS[2]),
                       sat_pix(sum_p1_q[p][1], OFFS[1]),
                       sat_pix(sum_p1_q[p][0], OFFS[0])};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0_q <= 1'b0;
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      vld_p0_q <= vld_p0_d;
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
    end
  end

  always_ff @(posedge clk) begin
    last_p0_q <= last_p0_d;
    last_p1_q <= last_p1_d;
    last_p2_q <= last_p2_d;
    prod_p0_q <= prod_p0_d;
    sum_p1_q  <= sum_p1_d;
    pix_p2_q  <= pix_p2_d;
  end

  // Output word is forced to zero whenever S3 is empty, which also covers reset.
  assign dst_valid = vld_p2_q;
  assign dst_last  = vld_p2_q & last_p2_q;
  assign dst_data  = vld_p2_q ? {8'h00, pix_p2_q[1], 8'h00, pix_p2_q[0]} : '0;

`ifdef RGB_TO_YUV444_STATS_EN
  logic [31:0] words_q, words_d;
  logic        done_q, done_d;
  logic        hs;

  assign hs = dst_valid & dst_ready;

  always_comb begin
    done_d  = hs & dst_last;
    words_d = done_q ? {31'd0, hs} : words_q + {31'd0, hs};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      words_q <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      words_q <= words_d;
      done_q  <= done_d;
    end
  end

  assign frame_words = words_q;
  assign frame_done  = done_q;
`endif

endmodule

// File: doc/rgb_to_yuv444.md
RGB_TO_YUV444 -- requirements
Module: rgb_to_yuv444

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, stream word width; only 64 is supported (two pixels per word).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port src_valid  input  1  input word valid.
REQ-005 SHALL have port src_ready  output  1  input word accepted when src_valid&src_ready at a clk edge.
REQ-006 SHALL have port src_data  input  64  two RGB pixels; pixel n in bits [32n+31:32n] as {pad[7:0], R[7:0], G[7:0], B[7:0]}; pad ignored.
REQ-007 SHALL have port src_last  input  1  marks final word of a frame.
REQ-008 SHALL have port dst_valid  output  1  output word valid.
REQ-009 SHALL have port dst_ready  input  1  downstream accepts when dst_valid&dst_ready.
REQ-010 SHALL have port dst_data  output  64  two YUV444 pixels; pixel n as {8'h00, V, U, Y} (Y in [7:0]).
REQ-011 SHALL have port dst_last  output  1  src_last carried with its word.

Function
REQ-012 SHALL convert each pixel independently per BT.601 studio range: Y=((66R+129G+25B+128)>>>8)+16; U=((-38R-74G+112B+128)>>>8)+128; V=((112R-94G-18B+128)>>>8)+128.
REQ-013 SHALL compute in signed arithmetic of at least 18 bits with arithmetic (floor) right shift, then saturate to 0..255.
REQ-014 SHALL be a 3-stage pipeline: S1 registered products, S2 registered sums, S3 registered offset/saturate driving dst_*; latency 3 cycles from acceptance to dst_valid with dst_ready held high.
REQ-015 SHALL sustain one word per cycle when dst_ready is continuously high.
REQ-016 Each stage SHALL hold a valid bit; a stage loads when it is empty or its contents advance in the same cycle (bubble collapse).
REQ-017 src_ready SHALL equal (S1 empty) OR (S1 advancing); it MAY depend combinationally on dst_ready.
REQ-018 dst_valid, dst_data and dst_last SHALL remain stable while dst_valid=1 and dst_ready=0.
REQ-019 Words SHALL leave in acceptance order, with none dropped or duplicated; src_last SHALL travel with its word.
REQ-020 Simultaneous accept at S1 and emit at S3 SHALL be handled in the same cycle without a bubble.
REQ-021 With the pipeline full and dst_ready=0, src_ready SHALL be 0 until dst_ready returns.

Reset
REQ-022 While rst=1: all stage valid bits=0, dst_valid=0, dst_data=0, dst_last=0, src_ready=0.
REQ-023 Reset asserted mid-frame SHALL discard all in-flight words immediately (asynchronously); no partial word is emitted after release.
REQ-024 src_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-025 Macro RGB_TO_YUV444_STATS_EN, when defined, SHALL add outputs frame_words (32, count of dst handshakes since the last frame end) and frame_done (1, one-cycle pulse on the dst handshake with dst_last=1).
REQ-026 With the macro defined, frame_words SHALL reset to 0 on the cycle after frame_done, and frame_words and frame_done SHALL reset to 0 on rst.
REQ-027 Without the macro, neither port SHALL exist and the datapath behaviour SHALL be identical.

Verification
REQ-028 Black/white: src_data=64'h00FFFFFF_00000000, dst_ready=1 -> after 3 cycles dst_data=64'h008080EB_00808010.
REQ-029 Red/blue: src_data=64'h000000FF_00FF0000 -> dst_data=64'h006EF029_00F05A52 (red Y82 U90 V240, blue Y41 U240 V110).
REQ-030 Back-to-back stream of 16 words with last on word 16, dst_ready=1 -> 16 outputs on 16 consecutive cycles, dst_last only on the 16th.
REQ-031 Backpressure: dst_ready=0 for 10 cycles during the stream -> src_ready=0 after 3 accepted words, dst_data stable, no loss or reordering after release.
REQ-032 Reset pulse with 2 words in flight -> dst_valid=0 immediately, no stale output afterwards, src_ready=1 the cycle after release.
REQ-033 STATS_EN build, 8-word frame -> frame_done pulses once with frame_words=8 on that cycle, then 0.
